// File: rtl/bin_img_pkg.sv
// Shared constants and types for the binary-image path (downscaler and upscaler).
package bin_img_pkg;

  localparam int IMG_IN_W  = 64;
  localparam int IMG_IN_H  = 32;
  localparam int IMG_OUT_W = 128;
  localparam int IMG_OUT_H = 64;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } upscale_state_t;

endpackage

// File: rtl/bin_upscale_2x.sv
// Nearest-neighbour 2x upscaler for a 1-bit raster stream: buffers one line, then emits it twice,
// each pixel doubled. Define UPSCALE_FRAME_MARK_EN to add dout_sof/dout_eol frame markers.
module bin_upscale_2x
  import bin_img_pkg::*;
#(
  parameter int IN_W = IMG_IN_W,
  parameter int IN_H = IMG_IN_H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_valid,
  input  logic din,
  output logic din_ready,
`ifdef UPSCALE_FRAME_MARK_EN
  output logic dout_sof,
  output logic dout_eol,
`endif
  output logic dout_valid,
  input  logic dout_ready,
  output logic dout
);

  localparam int CW = $clog2(IN_W);
  localparam int OW = CW + 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(2 * IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  upscale_state_t  state_q, state_d;
  logic [CW-1:0]   in_col_q, in_col_d;
  logic [OW-1:0]   out_col_q, out_col_d;
  logic [RW-1:0]   in_row_q, in_row_d;
  logic            rep_q, rep_d;
  logic [IN_W-1:0] line_buf_q, line_buf_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    state_d    = state_q;
    in_col_d   = in_col_q;
    out_col_d  = out_col_q;
    in_row_d   = in_row_q;
    rep_d      = rep_q;
    line_buf_d = line_buf_q;
    din_ready  = 1'b0;
    dout_valid = 1'b0;

    unique case (state_q)
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          line_buf_d[in_col_q] = din;
          if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            state_d  = EMIT;
          end else begin
            in_col_d = in_col_q + CW'(1);
          end
        end
      end

      EMIT: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (out_col_q == OUT_LAST) begin
            out_col_d = '0;
            rep_d     = ~rep_q;
            // Second copy of the line finished: fetch the next input line.
            if (rep_q) begin
              state_d  = LOAD;
              in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
            end
          end else begin
            out_col_d = out_col_q + OW'(1);
          end
        end
      end

      default: ;
    endcase
  end

  // Output pixel depends only on registered state; out_col/2 selects the source pixel.
  assign dout = (state_q == EMIT) & line_buf_q[out_col_q[OW-1:1]];

`ifdef UPSCALE_FRAME_MARK_EN
  assign dout_sof = (state_q == EMIT) && (in_row_q == '0) && !rep_q && (out_col_q == '0);
  assign dout_eol = (state_q == EMIT) && (out_col_q == OUT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      in_col_q   <= '0;
      out_col_q  <= '0;
      in_row_q   <= '0;
      rep_q      <= 1'b0;
      // NOTE: the line buffer is cleared on reset so a discarded partial line never reaches the output.
      line_buf_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register takes the value computed from pre-edge state.
      state_q    <= state_d;
      in_col_q   <= in_col_d;
      out_col_q  <= out_col_d;
      in_row_q   <= in_row_d;
      rep_q      <= rep_d;
      line_buf_q <= line_buf_d;
    end
  end

endmodule

// File: tb/tb_bin_upscale_2x.sv
// Scoreboard bench for bin_upscale_2x: the driver queues expected output per accepted line,
// a negedge monitor pops and compares on every output transfer.
module tb_bin_upscale_2x;
  import bin_img_pkg::*;

  localparam int W   = IMG_IN_W;
  localparam int H   = IMG_IN_H;
  localparam int OW2 = 2 * W;

  typedef struct packed {
    logic d;
    logic sof;
    logic eol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic din_ready;
  logic dout_valid;
  logic dout_ready = 1'b1;
  logic dout;
`ifdef UPSCALE_FRAME_MARK_EN
  logic dout_sof;
  logic dout_eol;
`endif

  int n_checks = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int sof_cnt = 0;
  int eol_cnt = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random ~30% low, 2: driven by the test
  exp_t exp_q[$];
  bit   prev_stall = 1'b0;
  logic prev_dout, prev_sof, prev_eol;
  bit [W-1:0] img [H];

  bin_upscale_2x #(.IN_W(W), .IN_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
`ifdef UPSCALE_FRAME_MARK_EN
    .dout_sof   (dout_sof),
    .dout_eol   (dout_eol),
`endif
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) dout_ready = 1'b1;
    else if (rdy_mode == 1) dout_ready = ($urandom_range(0, 9) >= 3);
  end

  // Monitor: compare each output transfer against the scoreboard, and hold during stalls.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_dout", 32'(dout), 32'(prev_dout));
`ifdef UPSCALE_FRAME_MARK_EN
        check("stall_sof", 32'(dout_sof), 32'(prev_sof));
        check("stall_eol", 32'(dout_eol), 32'(prev_eol));
`endif
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_out: got dout=%0b expected no output at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e.d));
`ifdef UPSCALE_FRAME_MARK_EN
          check("dout_sof", 32'(dout_sof), 32'(e.sof));
          check("dout_eol", 32'(dout_eol), 32'(e.eol));
          if (dout_sof) sof_cnt++;
          if (dout_eol) eol_cnt++;
`endif
        end
        xfer_cnt++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
`ifdef UPSCALE_FRAME_MARK_EN
      prev_sof   = dout_sof;
      prev_eol   = dout_eol;
`endif
    end
  end

  task automatic push_line(input bit [W-1:0] px, input int row);
    exp_t e;
    for (int rep = 0; rep < 2; rep++)
      for (int oc = 0; oc < OW2; oc++) begin
        e.d   = px[oc/2];
        e.sof = (row == 0 && rep == 0 && oc == 0);
        e.eol = (oc == OW2 - 1);
        exp_q.push_back(e);
      end
  endtask

  // Present one pixel and hold it until accepted (called at posedge+1, returns at posedge+1).
  task automatic drive_pixel(input bit v);
    bit acc;
    int k = 0;
    din_valid = 1'b1;
    din = v;
    do begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      k++;
      if (k > 3000) begin
        $display("FAIL din_accept_timeout: got din_ready=0 expected 1 within 3000 cycles");
        $fatal(1, "input stalled");
      end
    end while (!acc);
  endtask

  task automatic send_pixels(input bit [W-1:0] px, input int n, input bit gaps);
    for (int c = 0; c < n; c++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        din_valid = 1'b0;
        din = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive_pixel(px[c]);
    end
    din_valid = 1'b0;
  endtask

  task automatic send_line(input bit [W-1:0] px, input int row, input bit gaps);
    send_pixels(px, W, gaps);
    push_line(px, row);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    din_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit [W-1:0] px;
    int cnt, base;
    exp_t e;

    // Alternating line: din_ready must stay low for exactly 4*W emit cycles.
    rdy_mode = 0;
    apply_reset();
    for (int c = 0; c < W; c++) px[c] = (c % 2 == 0);
    send_line(px, 0, 1'b0);
    cnt = 0;
    while (cnt < 1000) begin
      @(negedge clk);
      if (din_ready) break;
      cnt++;
    end
    check("emit_cycles", 32'(cnt), 32'(4 * W));
    wait_drain();

    // Diagonal frame: output is 1 exactly where col/2 == row/2.
    apply_reset();
    base = xfer_cnt;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) px[c] = (c == r);
      send_pixels(px, W, 1'b0);
      for (int rep = 0; rep < 2; rep++)
        for (int oc = 0; oc < OW2; oc++) begin
          e.d   = ((oc / 2) == ((2 * r + rep) / 2));
          e.sof = (r == 0 && rep == 0 && oc == 0);
          e.eol = (oc == OW2 - 1);
          exp_q.push_back(e);
        end
    end
    wait_drain();
    check("frame_xfers", 32'(xfer_cnt - base), 32'(4 * W * H));

    // Random frame with input gaps and downstream stalls.
    apply_reset();
    rdy_mode = 1;
    for (int r = 0; r < H; r++) img[r] = {$urandom, $urandom};
    for (int r = 0; r < H; r++) send_line(img[r], r, 1'b1);
    wait_drain();
    rdy_mode = 0;

    // Long stall on the final pixel of the second copy of a line.
    apply_reset();
    rdy_mode = 2;
    dout_ready = 1'b1;
    px = {$urandom, $urandom};
    px[W-1] = 1'b1;
    px[W-2] = 1'b0;
    base = xfer_cnt;
    send_line(px, 0, 1'b0);
    cnt = 0;
    while (xfer_cnt < base + 4 * W - 1 && cnt < 2000) begin
      @(negedge clk);
      #2;
      cnt++;
    end
    check("pre_stall_xfers", 32'(xfer_cnt - base), 32'(4 * W - 1));
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("stall_last_valid", 32'(dout_valid), 32'd1);
      check("stall_last_dout", 32'(dout), 32'd1);
      check("stall_no_load", 32'(din_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    @(negedge clk);
    check("release_still_emit", 32'(din_ready), 32'd0);
    @(negedge clk);
    check("release_load", 32'(din_ready), 32'd1);
    check("release_xfers", 32'(xfer_cnt - base), 32'(4 * W));
    rdy_mode = 0;

    // Reset in the middle of line 5; a fresh frame must start from row 0.
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      img[r] = {$urandom, $urandom};
      send_line(img[r], r, 1'b0);
    end
    px = {$urandom, $urandom};
    send_pixels(px, 30, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_din_ready", 32'(din_ready), 32'd1);
    check("async_rst_dout_valid", 32'(dout_valid), 32'd0);
    check("async_rst_dout", 32'(dout), 32'd0);
    check("async_rst_no_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) send_line(~img[r], r, 1'b1);
    wait_drain();

`ifdef UPSCALE_FRAME_MARK_EN
    // Two back-to-back frames: count start-of-frame and end-of-line markers.
    apply_reset();
    sof_cnt = 0;
    eol_cnt = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++) send_line({$urandom, $urandom}, r, 1'b0);
    wait_drain();
    check("sof_count", 32'(sof_cnt), 32'd2);
    check("eol_count", 32'(eol_cnt), 32'(4 * H));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
